gerenciador_vagas: RTL and testbench
====================================

// Module: gerenciador_vagas
// PURPOSE
//  Sequencing controller for the parking lot's spot counter datapath.
//  Arbitrates entry and exit gate requests and allocates the lowest free spot on entry.
//  Releases the named spot on exit and holds the registered occupancy map.
//  Drives each gate for a fixed open time and publishes Ocupadas/Livres counts and a full flag.
// PARAMETERS
//  NUM_VAGAS    8   number of spots (map width); counts are $clog2(NUM_VAGAS+1) bits
//  GATE_CYCLES  16  clock cycles a gate output stays high per grant (>=1)
// PORTS
//  Clk             in   1   single clock, all state on rising edge
//  Rst_n           in   1   synchronous reset, active low
//  PedidoEntrada   in   1   entry request level, held by requester until AckEntrada/NegadoEntrada
//  PedidoSaida     in   1   exit request level, held until AckSaida/ErroSaida
//  VagaSaida       in   3   spot index being vacated, valid while PedidoSaida=1
//  Vagas           out  8   occupancy map, bit i=1 -> spot i occupied
//  Ocupadas        out  4   popcount(Vagas)
//  Livres          out  4   NUM_VAGAS - Ocupadas
//  Lotado          out  1   Ocupadas == NUM_VAGAS
//  CancelaEntrada  out  1   entry gate open
//  CancelaSaida    out  1   exit gate open
//  VagaAtribuida   out  3   spot allocated by last entry grant, valid with AckEntrada
//  AckEntrada      out  1   1-cycle pulse, entry granted
//  NegadoEntrada   out  1   1-cycle pulse, entry refused (lot full)
//  AckSaida        out  1   1-cycle pulse, exit granted
//  ErroSaida       out  1   1-cycle pulse, exit refused (spot already free or index >= NUM_VAGAS)
// BEHAVIOUR
//  Interface: one clock Clk; Rst_n synchronous, active low.
//  Reset values: all outputs 0 except Livres=NUM_VAGAS. FSM goes to IDLE, gate timer cleared, arbitration pointer set to "entry".
//  Reset mid-operation: gates close at the next edge; the occupancy map is cleared.
//  FSM states:
//   - IDLE: requests are sampled only in IDLE.
//   - ABRE_ENT / ABRE_SAI: requests are ignored.
//  Grant edge (IDLE, request present):
//   - Only PedidoEntrada: if Lotado, pulse NegadoEntrada and stay IDLE.
//     Else set the lowest-index 0 bit of Vagas, VagaAtribuida<=that index, pulse AckEntrada, go to ABRE_ENT.
//   - Only PedidoSaida: if VagaSaida is out of range or its bit is 0, pulse ErroSaida and stay IDLE.
//     Else clear the bit, pulse AckSaida, go to ABRE_SAI.
//   - Both requests: if Lotado, serve exit. Else serve the side not served by the previous grant (round robin).
//     The pointer updates on every grant, refusal or error.
//  Latency:
//   - Ack/Negado/Erro, map, counts and gate rise are all registered.
//   - All become visible the cycle after the sampling edge.
//   - Ocupadas/Livres/Lotado update in the same cycle as Vagas.
//  Gate timing:
//   - The gate output is high for exactly GATE_CYCLES cycles, then low, and the FSM returns to IDLE.
//   - The next request is sampled one cycle after the gate falls.
//  Re-sampling:
//   - A request still high in IDLE after its pulse is treated as new, so requesters must drop it on pulse.
//   - Consequence: a persistent refused request re-pulses every other cycle.
//  Only one of the four pulses may be high in any cycle.
//  Counts never wrap: at most NUM_VAGAS, never below 0.
// TESTING
//  1. Reset, PedidoEntrada 1 cycle -> AckEntrada, VagaAtribuida=0, Vagas=8'h01, Ocupadas=1, Livres=7, CancelaEntrada high 16 cycles.
//  2. 8 sequential entries -> Vagas=8'hFF, Lotado=1, Livres=0. 9th entry -> NegadoEntrada, no gate, map unchanged.
//  3. Vagas=8'hFF, exit VagaSaida=5 -> AckSaida, Vagas=8'hDF, Lotado=0. Next entry gets VagaAtribuida=5.
//  4. Exit VagaSaida=3 with bit 3 free -> ErroSaida, CancelaSaida stays 0, counts unchanged.
//  5. Both requests held, lot not full -> grants alternate entry/exit. While Lotado -> exit served first.
//  6. Rst_n low during ABRE_ENT -> next cycle: gates 0, Vagas=0, Livres=8, FSM IDLE.

Source files
------------

// File: rtl/gerenciador_vagas.sv
// Parking lot spot controller: arbitrates entry/exit gate requests,
// keeps the occupancy map, drives gates for a fixed time, publishes counts.
//
// Ports:
//   Clk, Rst_n         clock, synchronous active-low reset
//   PedidoEntrada      entry request level
//   PedidoSaida        exit request level, with VagaSaida (spot index)
//   Vagas              occupancy map (bit i = spot i occupied)
//   Ocupadas/Livres    occupied / free spot counts
//   Lotado             lot full
//   CancelaEntrada/Saida  gate open outputs
//   VagaAtribuida      spot given by last entry grant
//   AckEntrada/NegadoEntrada/AckSaida/ErroSaida  one-cycle result pulses
module gerenciador_vagas #(
    parameter int NUM_VAGAS   = 8,
    parameter int GATE_CYCLES = 16,
    localparam int IW = (NUM_VAGAS > 1) ? $clog2(NUM_VAGAS) : 1,
    localparam int CW = $clog2(NUM_VAGAS + 1),
    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 PedidoEntrada,
    input  logic                 PedidoSaida,
    input  logic [IW-1:0]        VagaSaida,
    output logic [NUM_VAGAS-1:0] Vagas,
    output logic [CW-1:0]        Ocupadas,
    output logic [CW-1:0]        Livres,
    output logic                 Lotado,
    output logic                 CancelaEntrada,
    output logic                 CancelaSaida,
    output logic [IW-1:0]        VagaAtribuida,
    output logic                 AckEntrada,
    output logic                 NegadoEntrada,
    output logic                 AckSaida,
    output logic                 ErroSaida
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ABRE_ENT,
        S_ABRE_SAI
    } estado_t;

    localparam logic [IW:0]   LP_NV    = (IW + 1)'(NUM_VAGAS);
    localparam logic [CW-1:0] LP_NV_C  = CW'(NUM_VAGAS);
    localparam logic [TW-1:0] LP_T_INI = TW'(GATE_CYCLES - 1);

    function automatic logic [IW-1:0] menor_livre(
        input logic [NUM_VAGAS-1:0] m
    );
        logic [IW-1:0] idx;
        idx = '0;
        // Scan downward so the last hit is the lowest free index.
        for (int i = NUM_VAGAS - 1; i >= 0; i--) begin
            if (!m[i]) idx = IW'(i);
        end
        return idx;
    endfunction

    function automatic logic [CW-1:0] popcount(
        input logic [NUM_VAGAS-1:0] m
    );
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < NUM_VAGAS; i++) begin
            c = c + CW'(m[i]);
        end
        return c;
    endfunction

    estado_t              r_estado;
    logic [TW-1:0]        r_timer;
    logic [NUM_VAGAS-1:0] r_vagas;
    logic [CW-1:0]        r_ocup;
    logic [CW-1:0]        r_livres;
    logic                 r_lotado;
    logic                 r_cancela_ent;
    logic                 r_cancela_sai;
    logic [IW-1:0]        r_vaga_atr;
    logic                 r_ack_ent;
    logic                 r_neg_ent;
    logic                 r_ack_sai;
    logic                 r_erro_sai;
    logic                 r_prio_sai;

    estado_t              w_estado_nxt;
    logic [TW-1:0]        w_timer_nxt;
    logic [NUM_VAGAS-1:0] w_vagas_nxt;
    logic [CW-1:0]        w_ocup_nxt;
    logic                 w_cancela_ent_nxt;
    logic                 w_cancela_sai_nxt;
    logic [IW-1:0]        w_vaga_atr_nxt;
    logic                 w_ack_ent_nxt;
    logic                 w_neg_ent_nxt;
    logic                 w_ack_sai_nxt;
    logic                 w_erro_sai_nxt;
    logic                 w_prio_sai_nxt;

    logic                 w_pulso;
    logic                 w_saida_ok;
    logic                 w_serve_sai;
    logic [IW-1:0]        w_livre_idx;

    // A pulse still showing means the requester has not had a chance to
    // drop its request yet, so this cycle is skipped for sampling.
    assign w_pulso = r_ack_ent | r_neg_ent | r_ack_sai | r_erro_sai;

    assign w_livre_idx = menor_livre(r_vagas);
    assign w_saida_ok  = ({1'b0, VagaSaida} < LP_NV) && r_vagas[VagaSaida];

    // A full lot can only make progress through an exit.
    assign w_serve_sai = (PedidoEntrada && PedidoSaida) ?
                         (r_lotado || r_prio_sai) : PedidoSaida;

    always_comb begin
        w_estado_nxt      = r_estado;
        w_timer_nxt       = r_timer;
        w_vagas_nxt       = r_vagas;
        w_cancela_ent_nxt = r_cancela_ent;
        w_cancela_sai_nxt = r_cancela_sai;
        w_vaga_atr_nxt    = r_vaga_atr;
        w_ack_ent_nxt     = 1'b0;
        w_neg_ent_nxt     = 1'b0;
        w_ack_sai_nxt     = 1'b0;
        w_erro_sai_nxt    = 1'b0;
        w_prio_sai_nxt    = r_prio_sai;

        unique case (r_estado)
            S_IDLE: begin
                if (!w_pulso && (PedidoEntrada || PedidoSaida)) begin
                    if (w_serve_sai) begin
                        w_prio_sai_nxt = 1'b0;
                        if (w_saida_ok) begin
                            w_vagas_nxt[VagaSaida] = 1'b0;
                            w_ack_sai_nxt          = 1'b1;
                            w_cancela_sai_nxt      = 1'b1;
                            w_timer_nxt            = LP_T_INI;
                            w_estado_nxt           = S_ABRE_SAI;
                        end else begin
                            w_erro_sai_nxt = 1'b1;
                        end
                    end else begin
                        w_prio_sai_nxt = 1'b1;
                        if (r_lotado) begin
                            w_neg_ent_nxt = 1'b1;
                        end else begin
                            w_vagas_nxt[w_livre_idx] = 1'b1;
                            w_vaga_atr_nxt           = w_livre_idx;
                            w_ack_ent_nxt            = 1'b1;
                            w_cancela_ent_nxt        = 1'b1;
                            w_timer_nxt              = LP_T_INI;
                            w_estado_nxt             = S_ABRE_ENT;
                        end
                    end
                end
            end
            S_ABRE_ENT, S_ABRE_SAI: begin
                if (r_timer == '0) begin
                    w_cancela_ent_nxt = 1'b0;
                    w_cancela_sai_nxt = 1'b0;
                    w_estado_nxt      = S_IDLE;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: begin
                w_cancela_ent_nxt = 1'b0;
                w_cancela_sai_nxt = 1'b0;
                w_estado_nxt      = S_IDLE;
            end
        endcase
    end

    // Counts are derived from the next map so they land with Vagas.
    assign w_ocup_nxt = popcount(w_vagas_nxt);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_estado      <= S_IDLE;
            r_timer       <= '0;
            r_vagas       <= '0;
            r_ocup        <= '0;
            r_livres      <= LP_NV_C;
            r_lotado      <= 1'b0;
            r_cancela_ent <= 1'b0;
            r_cancela_sai <= 1'b0;
            r_vaga_atr    <= '0;
            r_ack_ent     <= 1'b0;
            r_neg_ent     <= 1'b0;
            r_ack_sai     <= 1'b0;
            r_erro_sai    <= 1'b0;
            r_prio_sai    <= 1'b0;
        end else begin
            r_estado      <= w_estado_nxt;
            r_timer       <= w_timer_nxt;
            r_vagas       <= w_vagas_nxt;
            r_ocup        <= w_ocup_nxt;
            r_livres      <= LP_NV_C - w_ocup_nxt;
            r_lotado      <= (w_ocup_nxt == LP_NV_C);
            r_cancela_ent <= w_cancela_ent_nxt;
            r_cancela_sai <= w_cancela_sai_nxt;
            r_vaga_atr    <= w_vaga_atr_nxt;
            r_ack_ent     <= w_ack_ent_nxt;
            r_neg_ent     <= w_neg_ent_nxt;
            r_ack_sai     <= w_ack_sai_nxt;
            r_erro_sai    <= w_erro_sai_nxt;
            r_prio_sai    <= w_prio_sai_nxt;
        end
    end

    assign Vagas          = r_vagas;
    assign Ocupadas       = r_ocup;
    assign Livres         = r_livres;
    assign Lotado         = r_lotado;
    assign CancelaEntrada = r_cancela_ent;
    assign CancelaSaida   = r_cancela_sai;
    assign VagaAtribuida  = r_vaga_atr;
    assign AckEntrada     = r_ack_ent;
    assign NegadoEntrada  = r_neg_ent;
    assign AckSaida       = r_ack_sai;
    assign ErroSaida      = r_erro_sai;

endmodule

// File: tb/tb_gerenciador_vagas.sv
// Directed bench for gerenciador_vagas: entry/exit grants, refusals,
// round robin arbitration, gate timing and mid-operation reset.
module tb_gerenciador_vagas;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       PedidoEntrada;
    logic       PedidoSaida;
    logic [2:0] VagaSaida;
    logic [7:0] Vagas;
    logic [3:0] Ocupadas;
    logic [3:0] Livres;
    logic       Lotado;
    logic       CancelaEntrada;
    logic       CancelaSaida;
    logic [2:0] VagaAtribuida;
    logic       AckEntrada;
    logic       NegadoEntrada;
    logic       AckSaida;
    logic       ErroSaida;

    int total = 0;
    int bad   = 0;

    gerenciador_vagas #(
        .NUM_VAGAS  (8),
        .GATE_CYCLES(16)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .PedidoEntrada (PedidoEntrada),
        .PedidoSaida   (PedidoSaida),
        .VagaSaida     (VagaSaida),
        .Vagas         (Vagas),
        .Ocupadas      (Ocupadas),
        .Livres        (Livres),
        .Lotado        (Lotado),
        .CancelaEntrada(CancelaEntrada),
        .CancelaSaida  (CancelaSaida),
        .VagaAtribuida (VagaAtribuida),
        .AckEntrada    (AckEntrada),
        .NegadoEntrada (NegadoEntrada),
        .AckSaida      (AckSaida),
        .ErroSaida     (ErroSaida)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic req_ent();
        PedidoEntrada = 1'b1;
        tick();
        PedidoEntrada = 1'b0;
    endtask

    task automatic req_sai(input logic [2:0] v);
        VagaSaida   = v;
        PedidoSaida = 1'b1;
        tick();
        PedidoSaida = 1'b0;
    endtask

    task automatic fim();
        for (int i = 0; i < 64 && (CancelaEntrada || CancelaSaida); i++)
            tick();
        chk("gate_close", {CancelaEntrada, CancelaSaida}, 0);
        tick();
    endtask

    logic [7:0] exp_map [4] = '{8'hFF, 8'hFE, 8'hFF, 8'hFE};
    logic       exp_ent [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] exp_idx [4] = '{3'd3, 3'd0, 3'd0, 3'd0};

    initial begin
        int  n;
        logic got;

        Rst_n         = 1'b0;
        PedidoEntrada = 1'b0;
        PedidoSaida   = 1'b0;
        VagaSaida     = 3'd0;
        tick();
        tick();
        chk("rst_vagas", Vagas, 8'h00);
        chk("rst_ocup", Ocupadas, 0);
        chk("rst_livres", Livres, 8);
        chk("rst_lotado", Lotado, 0);
        chk("rst_gates", {CancelaEntrada, CancelaSaida}, 0);
        chk("rst_pulses",
            {AckEntrada, NegadoEntrada, AckSaida, ErroSaida}, 0);
        chk("rst_vaga_atr", VagaAtribuida, 0);
        Rst_n = 1'b1;
        tick();

        // 1: first entry and gate length
        req_ent();
        chk("t1_ack", AckEntrada, 1);
        chk("t1_vaga", VagaAtribuida, 0);
        chk("t1_map", Vagas, 8'h01);
        chk("t1_ocup", Ocupadas, 1);
        chk("t1_livres", Livres, 7);
        chk("t1_gate", CancelaEntrada, 1);
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (i == 0) chk("t1_ack_1cyc", AckEntrada, 0);
            if (!CancelaEntrada) break;
            n++;
        end
        chk("t1_gate_len", n, 16);
        tick();

        // 2: fill the lot, then one refused entry
        for (int v = 1; v < 8; v++) begin
            req_ent();
            chk("t2_ack", AckEntrada, 1);
            chk("t2_vaga", VagaAtribuida, v);
            fim();
        end
        chk("t2_map", Vagas, 8'hFF);
        chk("t2_lotado", Lotado, 1);
        chk("t2_livres", Livres, 0);
        chk("t2_ocup", Ocupadas, 8);
        req_ent();
        chk("t2_neg", NegadoEntrada, 1);
        chk("t2_no_ack", AckEntrada, 0);
        chk("t2_no_gate", CancelaEntrada, 0);
        chk("t2_map_kept", Vagas, 8'hFF);
        fim();

        // 3: exit spot 5, next entry reuses it
        req_sai(3'd5);
        chk("t3_ack", AckSaida, 1);
        chk("t3_err", ErroSaida, 0);
        chk("t3_map", Vagas, 8'hDF);
        chk("t3_lotado", Lotado, 0);
        chk("t3_ocup", Ocupadas, 7);
        chk("t3_livres", Livres, 1);
        chk("t3_gate", CancelaSaida, 1);
        fim();
        req_ent();
        chk("t3_ent_ack", AckEntrada, 1);
        chk("t3_ent_vaga", VagaAtribuida, 5);
        chk("t3_ent_map", Vagas, 8'hFF);
        fim();

        // 4: exit of an already free spot
        req_sai(3'd3);
        chk("t4_first_ack", AckSaida, 1);
        chk("t4_first_map", Vagas, 8'hF7);
        fim();
        req_sai(3'd3);
        chk("t4_err", ErroSaida, 1);
        chk("t4_no_ack", AckSaida, 0);
        chk("t4_no_gate", CancelaSaida, 0);
        chk("t4_ocup", Ocupadas, 7);
        chk("t4_map", Vagas, 8'hF7);
        fim();

        // 5: both held -> alternate; when full the exit wins
        VagaSaida     = 3'd0;
        PedidoEntrada = 1'b1;
        PedidoSaida   = 1'b1;
        for (int g = 0; g < 4; g++) begin
            got = 1'b0;
            for (int i = 0; i < 64; i++) begin
                tick();
                if (AckEntrada || NegadoEntrada || AckSaida || ErroSaida) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("t5_pulse_seen", got, 1);
            chk("t5_ack_ent", AckEntrada, exp_ent[g]);
            chk("t5_ack_sai", AckSaida, !exp_ent[g]);
            chk("t5_map", Vagas, exp_map[g]);
            if (exp_ent[g]) chk("t5_vaga", VagaAtribuida, exp_idx[g]);
        end
        PedidoEntrada = 1'b0;
        PedidoSaida   = 1'b0;
        fim();

        // persistent refused exit re-pulses every other cycle
        VagaSaida   = 3'd0;
        PedidoSaida = 1'b1;
        tick();
        chk("rp_err0", ErroSaida, 1);
        tick();
        chk("rp_err1", ErroSaida, 0);
        tick();
        chk("rp_err2", ErroSaida, 1);
        chk("rp_gate", CancelaSaida, 0);
        chk("rp_map", Vagas, 8'hFE);
        PedidoSaida = 1'b0;
        tick();
        tick();

        // 6: reset during the entry gate
        req_ent();
        chk("t6_ack", AckEntrada, 1);
        chk("t6_vaga", VagaAtribuida, 0);
        chk("t6_map", Vagas, 8'hFF);
        tick();
        tick();
        tick();
        chk("t6_gate_open", CancelaEntrada, 1);
        Rst_n = 1'b0;
        tick();
        chk("t6_gate_rst", {CancelaEntrada, CancelaSaida}, 0);
        chk("t6_map_rst", Vagas, 8'h00);
        chk("t6_livres_rst", Livres, 8);
        chk("t6_ocup_rst", Ocupadas, 0);
        chk("t6_lotado_rst", Lotado, 0);
        Rst_n = 1'b1;
        req_ent();
        chk("t6_idle_ack", AckEntrada, 1);
        chk("t6_idle_vaga", VagaAtribuida, 0);
        chk("t6_idle_map", Vagas, 8'h01);
        chk("t6_idle_gate", CancelaEntrada, 1);
        fim();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
